// File: rtl/mem_multicycle_if.sv
// Request/response bus of mem_multicycle.
// With MEM_MULTICYCLE_ALIGN_ERR_EN defined the bus also carries rsp_err.
interface mem_multicycle_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 16
);
  logic              req_valid;
  logic              req_wr;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              req_ready;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              busy;
`ifdef MEM_MULTICYCLE_ALIGN_ERR_EN
  logic              rsp_err;
`endif

  // Requester side
  modport master (
    output req_valid, req_wr, req_addr, req_wdata,
`ifdef MEM_MULTICYCLE_ALIGN_ERR_EN
    input  rsp_err,
`endif
    input  req_ready, rsp_valid, rsp_rdata, busy
  );

  // Memory side
  modport slave (
    input  req_valid, req_wr, req_addr, req_wdata,
`ifdef MEM_MULTICYCLE_ALIGN_ERR_EN
    output rsp_err,
`endif
    output req_ready, rsp_valid, rsp_rdata, busy
  );
endinterface

// File: rtl/mem_multicycle.sv
// Multi-cycle single-port word memory with valid/ready request handshake.
// One access in flight; response LATENCY cycles after acceptance.
// Optional: define MEM_MULTICYCLE_ALIGN_ERR_EN to flag odd addresses with
// rsp_err instead of performing the access.
module mem_multicycle #(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned DEPTH_LOG2 = 15,
  parameter int unsigned LATENCY    = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  mem_multicycle_if.slave bus
);

  localparam int unsigned CNT_W = 4;
  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [CNT_W-1:0]        r_cnt;
  logic [CNT_W-1:0]        w_cnt_nxt;
  logic                    w_accept;
  logic                    w_complete;
  logic                    w_misalign;
  logic                    w_do_write;
  logic                    w_do_read;
  logic                    w_unused_addr;

  logic                    r_req_ready;
  logic                    r_busy;
  logic                    r_rsp_valid;
  logic [DATA_W-1:0]       r_rsp_rdata;
  logic                    r_wr;
  logic [DEPTH_LOG2-1:0]   r_idx;
  logic [DATA_W-1:0]       r_wdata;
  logic [DATA_W-1:0]       r_mem [DEPTH];

  // Address bits outside the word index are intentionally dropped (aliasing)
  assign w_unused_addr = ^bus.req_addr;

  // Next-state and counter logic
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_accept    = 1'b0;
    w_complete  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.req_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_BUSY;
          w_cnt_nxt   = CNT_W'(LATENCY - 1);
        end
      end
      ST_BUSY: begin
        if (r_cnt == '0) begin
          w_complete  = 1'b1;
          w_state_nxt = ST_IDLE;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State, counter and registered handshake outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_req_ready <= 1'b1;
      r_busy      <= 1'b0;
      r_rsp_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_req_ready <= (w_state_nxt == ST_IDLE);
      r_busy      <= (w_state_nxt == ST_BUSY);
      r_rsp_valid <= w_complete;
    end
  end

  // Capture the request at acceptance; later input changes are ignored
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr    <= 1'b0;
      r_idx   <= '0;
      r_wdata <= '0;
    end else if (w_accept) begin
      r_wr    <= bus.req_wr;
      r_idx   <= bus.req_addr[DEPTH_LOG2:1];
      r_wdata <= bus.req_wdata;
    end
  end

`ifdef MEM_MULTICYCLE_ALIGN_ERR_EN
  logic r_misalign;
  logic r_rsp_err;

  // Odd address is remembered and reported instead of accessing the array
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_misalign <= 1'b0;
      r_rsp_err  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_misalign <= bus.req_addr[0];
      end
      r_rsp_err <= w_complete & r_misalign;
    end
  end

  assign w_misalign  = r_misalign;
  assign bus.rsp_err = r_rsp_err;
`else
  assign w_misalign = 1'b0;
`endif

  assign w_do_write = w_complete &  r_wr & ~w_misalign;
  assign w_do_read  = w_complete & ~r_wr & ~w_misalign;

  // Storage array; deliberately not reset
  always_ff @(posedge clk) begin
    if (w_do_write) begin
      r_mem[r_idx] <= r_wdata;
    end
  end

  // Read data holds until the next completed read
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_rdata <= '0;
    end else if (w_do_read) begin
      r_rsp_rdata <= r_mem[r_idx];
    end
  end

  assign bus.req_ready = r_req_ready;
  assign bus.busy      = r_busy;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_rdata = r_rsp_rdata;

endmodule

// File: tb/tb_mem_multicycle.sv
// Self-checking bench for mem_multicycle: behavioural model plus directed
// literal checks, then randomized request streams.
module tb_mem_multicycle;

  localparam int unsigned LAT = 4;
  localparam int unsigned DL  = 4;
  localparam int unsigned NW  = 1 << DL;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  mem_multicycle_if #(.DATA_W(16), .ADDR_W(16)) b ();
  mem_multicycle_if #(.DATA_W(16), .ADDR_W(16)) b1 ();

  mem_multicycle #(.DATA_W(16), .ADDR_W(16), .DEPTH_LOG2(DL), .LATENCY(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .bus(b)
  );

  mem_multicycle #(.DATA_W(16), .ADDR_W(16), .DEPTH_LOG2(15), .LATENCY(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(b1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model ----------------
  // m_rem: cycles left until the in-flight access completes (0 = idle)
  int          m_rem   = 0;
  bit          m_wr    = 0;
  int          m_idx   = 0;
  logic [15:0] m_wd    = '0;
  bit          m_mis   = 0;
  bit          m_valid = 0;
  bit          m_err   = 0;
  logic [15:0] m_rdata = '0;
  logic [15:0] m_mem [NW];
  int          n_model_rsp = 0;
  int          n_dut_rsp   = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_rem = 0; m_valid = 0; m_err = 0; m_rdata = '0;
    end else begin
      m_valid = 0;
      m_err   = 0;
      if (m_rem > 0) begin
        m_rem--;
        if (m_rem == 0) begin
          m_valid = 1;
          n_model_rsp++;
          if (m_mis)     m_err = 1;
          else if (m_wr) m_mem[m_idx] = m_wd;
          else           m_rdata = m_mem[m_idx];
        end
      end else if (b.req_valid) begin
        m_rem = LAT;
        m_wr  = b.req_wr;
        m_idx = int'((b.req_addr >> 1) % NW);
        m_wd  = b.req_wdata;
`ifdef MEM_MULTICYCLE_ALIGN_ERR_EN
        m_mis = b.req_addr[0];
`else
        m_mis = 0;
`endif
      end
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    chk("req_ready", 32'(b.req_ready), 32'(m_rem == 0));
    chk("busy",      32'(b.busy),      32'(m_rem != 0));
    chk("rsp_valid", 32'(b.rsp_valid), 32'(m_valid));
    chk("rsp_rdata", 32'(b.rsp_rdata), 32'(m_rdata));
`ifdef MEM_MULTICYCLE_ALIGN_ERR_EN
    chk("rsp_err",   32'(b.rsp_err),   32'(m_err));
`endif
    if (b.rsp_valid) n_dut_rsp++;
  end

  // ---------------- stimulus helpers ----------------
  // Starts and ends on a falling edge; lat = cycles from accept to rsp_valid
  task automatic do_access(input bit wr, input logic [15:0] addr, input logic [15:0] wd,
                           output int lat, output logic [15:0] rd, output bit err);
    lat = -1; rd = '0; err = 0;
    for (int g = 0; g < 50 && !b.req_ready; g++) @(negedge clk);
    if (!b.req_ready) begin
      chk("accept_timeout", 32'(b.req_ready), 32'd1);
      return;
    end
    b.req_valid = 1'b1; b.req_wr = wr; b.req_addr = addr; b.req_wdata = wd;
    @(negedge clk);
    b.req_valid = 1'b0;
    b.req_addr  = 16'($urandom);
    b.req_wdata = 16'($urandom);
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (b.rsp_valid) begin
        lat = n;
        rd  = b.rsp_rdata;
`ifdef MEM_MULTICYCLE_ALIGN_ERR_EN
        err = b.rsp_err;
`endif
        break;
      end
    end
  endtask

  // Random stream; requester holds each request until accepted
  task automatic run_stream(input int n, input int gap_pct, output int first_acc, output int last_acc);
    bit pending = 0;
    bit rdy     = 0;
    int acc     = 0;
    first_acc = -1; last_acc = -1;
    for (int g = 0; g < 20000; g++) begin
      if (pending && rdy) begin
        if (first_acc < 0) first_acc = cyc;
        last_acc = cyc;
        acc++;
        pending = 0;
      end
      if (acc >= n) break;
      if (!pending) begin
        if (int'($urandom_range(99)) >= gap_pct) begin
          b.req_valid = 1'b1;
          b.req_wr    = 1'($urandom);
          b.req_addr  = 16'($urandom_range(0, 255));
          b.req_wdata = 16'($urandom);
          pending = 1;
        end else begin
          b.req_valid = 1'b0;
          b.req_addr  = 16'($urandom);
        end
      end
      rdy = b.req_ready;
      @(negedge clk);
    end
    b.req_valid = 1'b0;
    chk("stream_accepts", 32'(acc), 32'(n));
    repeat (LAT + 2) @(negedge clk);
  endtask

  // ---------------- main sequence ----------------
  int          lat;
  logic [15:0] rd;
  bit          err;
  int          fa, la, pulses;

  initial begin
    b.req_valid = 0; b.req_wr = 0; b.req_addr = '0; b.req_wdata = '0;
    b1.req_valid = 0; b1.req_wr = 0; b1.req_addr = '0; b1.req_wdata = '0;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_ready", 32'(b.req_ready), 32'd1);
    chk("reset_rdata", 32'(b.rsp_rdata), 32'd0);

    // Give every word a known value
    for (int i = 0; i < int'(NW); i++)
      do_access(1'b1, 16'(i * 2), 16'($urandom), lat, rd, err);

    // Write then read back 0xBEEF at 0x0010
    do_access(1'b1, 16'h0010, 16'hBEEF, lat, rd, err);
    chk("wr_latency", 32'(lat), 32'd4);
    do_access(1'b0, 16'h0010, 16'h0000, lat, rd, err);
    chk("rd_latency", 32'(lat), 32'd4);
    chk("rd_beef", 32'(rd), 32'h0000BEEF);

    // Aliasing with 16 words: 0x0022 maps onto 0x0002
    do_access(1'b1, 16'h0002, 16'h1234, lat, rd, err);
    do_access(1'b0, 16'h0022, 16'h0000, lat, rd, err);
    chk("alias_rd", 32'(rd), 32'h00001234);

    // Reset in the middle of a write aborts it
    do_access(1'b1, 16'h0004, 16'h5555, lat, rd, err);
    b.req_valid = 1'b1; b.req_wr = 1'b1; b.req_addr = 16'h0004; b.req_wdata = 16'hAAAA;
    @(posedge clk);
    @(negedge clk);
    b.req_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_ready", 32'(b.req_ready), 32'd1);
    chk("async_busy",  32'(b.busy),      32'd0);
    chk("async_valid", 32'(b.rsp_valid), 32'd0);
    chk("async_rdata", 32'(b.rsp_rdata), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    repeat (8) begin
      @(negedge clk);
      if (b.rsp_valid) pulses++;
    end
    chk("abort_no_rsp", 32'(pulses), 32'd0);
    do_access(1'b0, 16'h0004, 16'h0000, lat, rd, err);
    chk("abort_keeps_old", 32'(rd), 32'h00005555);

`ifdef MEM_MULTICYCLE_ALIGN_ERR_EN
    // Odd address: error pulse, no write, rdata unchanged
    do_access(1'b1, 16'h0011, 16'h7777, lat, rd, err);
    chk("misalign_err", 32'(err), 32'd1);
    chk("misalign_lat", 32'(lat), 32'd4);
    chk("misalign_rdata", 32'(rd), 32'h00005555);
    do_access(1'b0, 16'h0010, 16'h0000, lat, rd, err);
    chk("aligned_err", 32'(err), 32'd0);
    chk("aligned_keeps", 32'(rd), 32'h0000BEEF);
`endif

    // LATENCY=1 instance: one BUSY cycle
    b1.req_valid = 1'b1; b1.req_wr = 1'b1; b1.req_addr = 16'h0100; b1.req_wdata = 16'h5A5A;
    @(negedge clk);
    b1.req_valid = 1'b0;
    chk("l1_busy",       32'(b1.busy),      32'd1);
    chk("l1_not_ready",  32'(b1.req_ready), 32'd0);
    chk("l1_no_rsp_yet", 32'(b1.rsp_valid), 32'd0);
    @(negedge clk);
    chk("l1_wr_rsp",   32'(b1.rsp_valid), 32'd1);
    chk("l1_ready",    32'(b1.req_ready), 32'd1);
    b1.req_valid = 1'b1; b1.req_wr = 1'b0; b1.req_addr = 16'h0100;
    @(negedge clk);
    b1.req_valid = 1'b0;
    @(negedge clk);
    chk("l1_rd_rsp",   32'(b1.rsp_valid), 32'd1);
    chk("l1_rd_data",  32'(b1.rsp_rdata), 32'h00005A5A);
    @(negedge clk);
    chk("l1_rsp_pulse", 32'(b1.rsp_valid), 32'd0);

    // Back-to-back: one accept every LATENCY+1 cycles
    run_stream(60, 0, fa, la);
    chk("throughput", 32'(la - fa), 32'(59 * 5));

    // Gappy random traffic
    run_stream(150, 60, fa, la);

    chk("rsp_count", 32'(n_dut_rsp), 32'(n_model_rsp));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

endmodule
